// File: rtl/ps2_kbd_evq.sv
// ps2_kbd_evq: PS/2 keyboard receiver turning raw pin activity into decoded make/break/extended key events.
// Latency: event pushed 1 clk after the 11th ps2_clk falling edge; visible at the queue head 1 clk later.
// Backpressure: evt_ready pops the head; the keyboard cannot be stalled, so a push into a full queue is dropped and flagged.

// ps2_evq_fifo: generic show-ahead FIFO with occupancy count.
// Latency: a push is visible at the head the cycle after it is written; no bypass.
// Backpressure: push while full is accepted only if a pop happens in the same cycle; otherwise drop pulses.
module ps2_evq_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign rd_en    = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign wr_en    = push && (!full || rd_en);
  assign drop     = push && !wr_en;
  assign head_dat = mem[rd_ptr];

  // Storage write; contents need no reset since the head is qualified by level.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy 0..DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// ps2_kbd_evq: PS/2 receiver with frame checking, E0/F0 prefix decoding and an event queue.
// Latency: push 1 clk after the 11th falling edge, evt_valid the cycle after that.
// Backpressure: evt_valid/evt_ready on the head; pushes into a full queue without a pop are dropped (overflow).
module ps2_kbd_evq #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT     = 20000,
  parameter int ERR_W       = 8
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  input  logic                   evt_ready,
  input  logic                   clr_err,
  output logic                   evt_valid,
  output logic [7:0]             evt_code,
  output logic                   evt_ext,
  output logic                   evt_brk,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   frame_err,
  output logic [ERR_W-1:0]       err_count,
  output logic                   sampling
);
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int EW1 = ERR_W + 1;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   fall;
  logic                   ps2_bit;
  logic [10:0]            frame_sr;
  logic [3:0]             bit_cnt;
  logic [TW-1:0]          to_cnt;
  logic                   to_hit;
  logic                   frame_done;
  logic                   frame_ok;
  logic [7:0]             frame_byte;
  logic                   ext_flag;
  logic                   brk_flag;
  logic                   push;
  evt_t                   push_evt;
  evt_t                   head_evt;
  logic                   fifo_empty;
  logic                   drop;
  logic                   err_pend;
  logic                   ovf_pend;
  logic [1:0]             err_inc;
  logic [ERR_W:0]         err_sum;

  // Synchroniser chains for both pins; reset to 1 so an idle bus never looks like an edge.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Falling edge: oldest stage still high, next stage already low.
  assign fall     = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  // Data is stable across the falling edge, so the oldest data stage is a safe sample.
  assign ps2_bit  = dat_sync[SYNC_STAGES-1];
  assign sampling = fall;

  // A partial frame is abandoned once TIMEOUT cycles pass with no falling edge.
  assign to_hit = (bit_cnt != 4'd0) && !fall && (to_cnt == TW'(TIMEOUT - 1));

  // Bit collection: shift LSB-first into frame_sr, count 0..10, and watch for a stalled frame.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      frame_sr   <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (fall) begin
        frame_sr <= {ps2_bit, frame_sr[10:1]};
        to_cnt   <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (to_hit) begin
        bit_cnt <= '0;
        to_cnt  <= '0;
      end else if (bit_cnt != 4'd0) begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

  // After 11 shifts: [0]=start, [8:1]=data, [9]=odd parity, [10]=stop.
  assign frame_byte = frame_sr[8:1];
  assign frame_ok   = !frame_sr[0] && frame_sr[10] && (^frame_sr[9:1]);
  assign frame_err  = (frame_done && !frame_ok) || to_hit;
  assign push       = frame_done && frame_ok && (frame_byte != 8'hE0) && (frame_byte != 8'hF0);

  // Event word built from the current prefix flags and the received byte.
  always_comb begin
    push_evt      = '0;
    push_evt.ext  = ext_flag;
    push_evt.brk  = brk_flag;
    push_evt.code = frame_byte;
  end

  // Prefix flags: E0/F0 arm ext/brk, any other good byte consumes them, a bad frame discards them.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (frame_err) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (frame_done) begin
      if (frame_byte == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (frame_byte == 8'hF0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  ps2_evq_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (clrn),
    .push     (push),
    .push_dat (push_evt),
    .pop      (evt_ready),
    .head_dat (head_evt),
    .empty    (fifo_empty),
    .drop     (drop),
    .level    (level)
  );

  // Head outputs are forced to zero while empty so stale storage never shows.
  assign evt_valid = !fifo_empty;
  assign evt_code  = evt_valid ? head_evt.code : 8'h00;
  assign evt_ext   = evt_valid & head_evt.ext;
  assign evt_brk   = evt_valid & head_evt.brk;

  // Saturating increment; a pending event deferred by clr_err adds on top of any new pulse.
  assign err_inc = {1'b0, frame_err} + {1'b0, err_pend};
  assign err_sum = {1'b0, err_count} + EW1'(err_inc);

  // Error counter and sticky overflow; clr_err wins its cycle and a coincident event lands the next cycle.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      err_count <= '0;
      err_pend  <= 1'b0;
      overflow  <= 1'b0;
      ovf_pend  <= 1'b0;
    end else if (clr_err) begin
      err_count <= '0;
      err_pend  <= frame_err;
      overflow  <= 1'b0;
      ovf_pend  <= drop;
    end else begin
      err_pend  <= 1'b0;
      ovf_pend  <= 1'b0;
      err_count <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
      if (drop || ovf_pend) begin
        overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ps2_kbd_evq.sv
// tb_ps2_kbd_evq: directed PS/2 frames with a scoreboard of expected events.
// Stimulus pushes expected events; a negedge monitor pops and compares on every handshake.
// Counts sampling and frame_err pulses for the directed timing checks.
module tb_ps2_kbd_evq;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 3;
  localparam int TIMEOUT     = 300;
  localparam int ERR_W       = 8;
  localparam int HALF        = 6;

  logic                   clk = 1'b0;
  logic                   clrn = 1'b1;
  logic                   ps2_clk = 1'b1;
  logic                   ps2_data = 1'b1;
  logic                   evt_ready = 1'b0;
  logic                   clr_err = 1'b0;
  logic                   evt_valid;
  logic [7:0]             evt_code;
  logic                   evt_ext;
  logic                   evt_brk;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
  logic                   frame_err;
  logic [ERR_W-1:0]       err_count;
  logic                   sampling;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int samp_cnt = 0;
  int err_pulses = 0;
  int last_samp_cyc = 0;
  int last_err_cyc = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic [9:0] exp_q [$];

  ps2_kbd_evq #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT),
    .ERR_W       (ERR_W)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .evt_ready (evt_ready),
    .clr_err   (clr_err),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_brk   (evt_brk),
    .level     (level),
    .overflow  (overflow),
    .frame_err (frame_err),
    .err_count (err_count),
    .sampling  (sampling)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pulse counters plus the scoreboard compare on each accepted head event.
  always @(negedge clk) begin
    logic [9:0] got;
    logic [9:0] exp;
    cyc++;
    if (!clrn) begin
      if (sampling) begin
        samp_cnt++;
        last_samp_cyc = cyc;
      end
      if (frame_err) begin
        err_pulses++;
        last_err_cyc = cyc;
      end
      if (evt_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = evt_valid;
      if (evt_valid && evt_ready) begin
        got = {evt_ext, evt_brk, evt_code};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL event: got %h expected %h", got, exp);
          end
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  function automatic logic [10:0] mkframe(input logic [7:0] b, input bit bad_par,
                                          input bit bad_stop, input bit bad_start);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, bad_start};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: plain; 1: pulse evt_ready in the push cycle; 2: pulse clr_err in the push cycle.
  task automatic ps2_send(input logic [10:0] bits, input int nbits, input int mode);
    bit seen;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      if (i == 10 && mode != 0) begin
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
          @(negedge clk);
          if (sampling) seen = 1'b1;
        end
        if (!seen) chk("edge_seen", 0, 1);
        @(posedge clk); #1;
        if (mode == 1) evt_ready = 1'b1; else clr_err = 1'b1;
        @(posedge clk); #1;
        evt_ready = 1'b0;
        clr_err   = 1'b0;
      end
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cycles(HALF);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (level != 0 && n < 200) begin
      wait_cycles(1);
      n++;
    end
    chk(name, level, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int s;

    // Reset state
    wait_cycles(3);
    chk("rst_valid", evt_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_samp", sampling, 0);
    chk("rst_code", evt_code, 0);
    clrn = 1'b0;
    wait_cycles(3);

    // Single 0x1C make code: latency and sampling count
    samp_cnt = 0;
    exp_q.push_back({2'b00, 8'h1C});
    ps2_send(mkframe(8'h1C, 0, 0, 0), 11, 0);
    chk("samp_count", samp_cnt, 11);
    chk("latency", rise_cyc - last_samp_cyc, 2);
    chk("head_code", evt_code, 8'h1C);
    chk("level1", level, 1);
    evt_ready = 1'b1;
    wait_drain("drain1");

    // Prefix sequences held in the queue, then popped
    evt_ready = 1'b0;
    exp_q.push_back({2'b01, 8'h1C});
    exp_q.push_back({2'b11, 8'h75});
    exp_q.push_back({2'b10, 8'h6B});
    ps2_send(mkframe(8'hF0, 0, 0, 0), 11, 0);
    ps2_send(mkframe(8'h1C, 0, 0, 0), 11, 0);
    ps2_send(mkframe(8'hE0, 0, 0, 0), 11, 0);
    ps2_send(mkframe(8'hF0, 0, 0, 0), 11, 0);
    ps2_send(mkframe(8'h75, 0, 0, 0), 11, 0);
    ps2_send(mkframe(8'hE0, 0, 0, 0), 11, 0);
    ps2_send(mkframe(8'h6B, 0, 0, 0), 11, 0);
    chk("level3", level, 3);
    evt_ready = 1'b1;
    wait_drain("drain3");

    // Bad parity, bad stop after E0, bad start after F0
    base = err_pulses;
    ps2_send(mkframe(8'h1C, 1, 0, 0), 11, 0);
    chk("par_pulse", err_pulses - base, 1);
    chk("par_cnt", err_count, 1);
    chk("par_level", level, 0);
    exp_q.push_back({2'b00, 8'h74});
    ps2_send(mkframe(8'hE0, 0, 0, 0), 11, 0);
    ps2_send(mkframe(8'h12, 0, 1, 0), 11, 0);
    ps2_send(mkframe(8'h74, 0, 0, 0), 11, 0);
    chk("stop_cnt", err_count, 2);
    exp_q.push_back({2'b00, 8'h74});
    ps2_send(mkframe(8'hF0, 0, 0, 0), 11, 0);
    ps2_send(mkframe(8'h55, 0, 0, 1), 11, 0);
    ps2_send(mkframe(8'h74, 0, 0, 0), 11, 0);
    chk("start_cnt", err_count, 3);
    wait_drain("drain_err");

    // Overflow with no pops
    evt_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back({2'b00, 8'(b)});
      ps2_send(mkframe(8'(b), 0, 0, 0), 11, 0);
    end
    chk("full_level", level, 4);
    chk("ovf_set", overflow, 1);
    evt_ready = 1'b1;
    wait_drain("drain_full");
    chk("ovf_sticky", overflow, 1);
    clr_err = 1'b1;
    wait_cycles(1);
    clr_err = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_cnt", err_count, 0);

    // Push while full with a coincident pop
    evt_ready = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      exp_q.push_back({2'b00, 8'(b)});
      ps2_send(mkframe(8'(b), 0, 0, 0), 11, 0);
    end
    chk("full_level2", level, 4);
    exp_q.push_back({2'b00, 8'h05});
    ps2_send(mkframe(8'h05, 0, 0, 0), 11, 1);
    chk("pp_level", level, 4);
    chk("pp_ovf", overflow, 0);
    evt_ready = 1'b1;
    wait_drain("drain_pp");

    // Stall timeout after 5 bits, then recovery
    base = err_pulses;
    ps2_send(mkframe(8'h29, 0, 0, 0), 5, 0);
    s = last_samp_cyc;
    wait_cycles(TIMEOUT + 5);
    chk("to_pulse", err_pulses - base, 1);
    chk("to_delay", last_err_cyc - s, TIMEOUT);
    chk("to_cnt", err_count, 1);
    exp_q.push_back({2'b00, 8'h29});
    ps2_send(mkframe(8'h29, 0, 0, 0), 11, 0);
    wait_drain("drain_to");

    // clr_err coinciding with a frame error: clear first, then count 1
    ps2_send(mkframe(8'h33, 1, 0, 0), 11, 2);
    chk("clr_coinc", err_count, 1);

    // Reset mid-frame with two events queued
    evt_ready = 1'b0;
    exp_q.push_back({2'b00, 8'h11});
    exp_q.push_back({2'b00, 8'h22});
    ps2_send(mkframe(8'h11, 0, 0, 0), 11, 0);
    ps2_send(mkframe(8'h22, 0, 0, 0), 11, 0);
    chk("level2", level, 2);
    ps2_send(mkframe(8'h5A, 0, 0, 0), 6, 0);
    clrn = 1'b1;
    #2;
    chk("mrst_valid", evt_valid, 0);
    chk("mrst_level", level, 0);
    chk("mrst_err", err_count, 0);
    chk("mrst_code", evt_code, 0);
    exp_q.delete();
    wait_cycles(3);
    clrn = 1'b0;
    wait_cycles(3);
    evt_ready = 1'b1;
    exp_q.push_back({2'b00, 8'h5A});
    ps2_send(mkframe(8'h5A, 0, 0, 0), 11, 0);
    wait_drain("drain_rst");
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_evq.md
Name: ps2_kbd_evq

Overview:
- Next-generation PS/2 keyboard receiver: ps2_clk synchroniser, frame checker, scan-code prefix decoder and parametrised event FIFO with valid/ready handshake.
- Sits between the PS/2 pins and the display/consumer logic.
- Adds the following: decoded make/break/extended events, parity/start/stop checking, stall timeout with resync, error counter, and configurable queue depth.

Parameters:
- DEPTH, 8, event FIFO entries; power of 2, minimum 2.
- SYNC_STAGES, 3, flops on ps2_clk and ps2_data; minimum 2.
- TIMEOUT, 20000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous reset, active-high.
- ps2_clk  in  1  raw PS/2 clock.
- ps2_data  in  1  raw PS/2 data.
- evt_ready  in  1  consumer accepts the head event.
- clr_err  in  1  synchronous clear of overflow and err_count.
- evt_valid  out  1  FIFO not empty.
- evt_code  out  8  head event scan code.
- evt_ext  out  1  head event was preceded by E0.
- evt_brk  out  1  head event was preceded by F0 (key release).
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; an event was dropped.
- frame_err  out  1  one-cycle pulse on a rejected or timed-out frame.
- err_count  out  ERR_W  saturating count of frame_err pulses.
- sampling  out  1  one-cycle pulse on each accepted ps2_clk falling edge.

Behaviour:
- Reset: all outputs 0, FIFO empty, bit counter 0, prefix flags 0, timeout counter 0. Sync flops reset to 1 (idle bus). Reset mid-frame discards the partial frame.
- Edge detect: a falling edge is detected when the last two sync stages read 1 then 0. sampling pulses that cycle, and ps2_data (synchronised) is shifted in that cycle.
- Frame format, 11 bits:
  - bit0 start = 0.
  - bits1-8 data, LSB first.
  - bit9 odd parity: XOR of data and parity = 1.
  - bit10 stop = 1.
- Bit counter runs 0..10. On the 11th edge the frame is checked and the counter returns to 0.
- Bad start, parity or stop: frame_err pulses the cycle after the 11th edge, the byte is discarded, and prefix flags are cleared.
- Timeout: the counter resets on every falling edge. It counts only while the bit counter ≠ 0. On reaching TIMEOUT, the bit counter goes to 0, frame_err pulses, and prefix flags are cleared.
- Decoder (good byte, the cycle after the 11th edge):
  - 0xE0: set ext flag; nothing is pushed.
  - 0xF0: set brk flag; nothing is pushed.
  - Any other byte: push {ext, brk, byte} and clear both flags.
  - Repeated prefixes are idempotent.
- Latency: the push happens 1 cycle after the 11th edge; evt_valid and the head data are visible the following cycle. There is no bypass path.
- FIFO: show-ahead; evt_code, evt_ext and evt_brk are valid whenever evt_valid = 1. A pop happens when evt_valid && evt_ready; evt_ready while empty has no effect.
- Full:
  - Push while full with no pop: the event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both succeed, level unchanged, no overflow.
  - Push and pop while non-empty: level unchanged.
- Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
- err_count increments on each frame_err pulse and saturates at all-ones.
- clr_err clears overflow and err_count. If clr_err coincides with a new event, the clear wins for that cycle and the event takes effect the next cycle (count becomes 1, or overflow sets).

Test Plan:
- Reset, then send a valid frame with byte 0x1C (parity 0) → one event: code=0x1C, ext=0, brk=0. evt_valid rises 2 cycles after the 11th edge; sampling pulses 11 times.
- Send F0,1C, then E0,F0,75, then E0,6B → three events in order: (1C,ext0,brk1), (75,ext1,brk1), (6B,ext1,brk0). level reaches 3 with evt_ready=0, then pops to 0.
- Send 0x1C with the parity bit flipped → frame_err pulses once, err_count=1, no event. Send E0 then a bad-stop frame, then 0x74 → event (74,ext0,brk0) confirms prefix flags were cleared.
- DEPTH=4, evt_ready=0, send bytes 01..05 → level=4, overflow=1, pops return 01,02,03,04. Repeat while full with evt_ready=1 during the 5th push → no overflow.
- Drive 5 bits, then idle TIMEOUT+5 cycles → frame_err pulses exactly at TIMEOUT, err_count=1; a following valid 0x29 frame decodes correctly. Assert clr_err → overflow=0, err_count=0.
- Assert clrn mid-frame (bit 6) and mid-queue (level=2) → all outputs 0 immediately; the next full frame 0x5A decodes correctly.
